// File: rtl/rvb_mem_responder.sv
// rvb_mem_responder: picorv32 native-bus responder with RAM and console FIFO.
// Optional "ERROR" lookback detector enabled by RVB_MEM_RESPONDER_LOOKBACK_EN.
module rvb_mem_responder #(
    parameter int          MEM_WORDS    = 4096,
    parameter int          WAIT_CYCLES  = 0,
    parameter int          FIFO_DEPTH   = 16,
    parameter logic [31:0] CONSOLE_ADDR = 32'h1000_0000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        mem_valid,
    input  logic        mem_instr,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    input  logic [3:0]  mem_wstrb,
    output logic        mem_ready,
    output logic [31:0] mem_rdata,
    output logic        con_valid,
    output logic [7:0]  con_data,
    input  logic        con_ready,
    output logic        bus_error,
    output logic        lookback_hit
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

    localparam int AW = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
    localparam int PW = $clog2(FIFO_DEPTH);

    logic [1:0]    state;
    logic [3:0]    wait_cnt;
    logic [31:0]   addr_q;
    logic [31:0]   wdata_q;
    logic [3:0]    wstrb_q;
    logic [31:0]   rdata_q;
    logic          ready_q;
    logic          bus_error_q;

    logic [31:0]   ram [MEM_WORDS];
    logic [7:0]    fifo [FIFO_DEPTH];
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic [4:0]    count;

    logic [AW-1:0] ram_idx;
    logic          hit_ram;
    logic          hit_con;
    logic          is_push;
    logic          fifo_full;
    logic          done;
    logic          push;
    logic          pop;
    logic [31:0]   rd_word;
    logic          unused_instr;

    // Instruction fetches decode exactly like data accesses.
    assign unused_instr = mem_instr;

    // Address decode and completion conditions for the latched request.
    always_comb begin
        ram_idx   = addr_q[AW+1:2];
        hit_ram   = addr_q[31:2] < 30'(MEM_WORDS);
        hit_con   = (addr_q == CONSOLE_ADDR) && !hit_ram;
        is_push   = hit_con && (wstrb_q != 4'b0);
        fifo_full = count == 5'(FIFO_DEPTH);
        done      = (state == S_WAIT)
                 && (wait_cnt == 4'(WAIT_CYCLES))
                 && !(is_push && fifo_full);
        push      = done && is_push;
        pop       = (count != 5'd0) && con_ready;
        rd_word   = 32'b0;
        if (hit_ram) begin
            rd_word = ram[ram_idx];
        end else if (hit_con) begin
            rd_word = {27'b0, count};
        end
    end

    // Request FSM: capture, count wait states, respond for one cycle.
    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= S_IDLE;
            wait_cnt    <= 4'd0;
            addr_q      <= 32'b0;
            wdata_q     <= 32'b0;
            wstrb_q     <= 4'b0;
            rdata_q     <= 32'b0;
            ready_q     <= 1'b0;
            bus_error_q <= 1'b0;
        end else begin
            ready_q <= 1'b0;
            rdata_q <= 32'b0;
            case (state)
                S_IDLE: begin
                    if (mem_valid) begin
                        addr_q   <= mem_addr;
                        wdata_q  <= mem_wdata;
                        wstrb_q  <= mem_wstrb;
                        wait_cnt <= 4'd0;
                        state    <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (done) begin
                        state   <= S_RESP;
                        ready_q <= 1'b1;
                        rdata_q <= rd_word;
                        if (!hit_ram && !hit_con) begin
                            bus_error_q <= 1'b1;
                        end
                    end else if (wait_cnt != 4'(WAIT_CYCLES)) begin
                        wait_cnt <= wait_cnt + 4'd1;
                    end
                end
                S_RESP:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    // RAM byte-lane writes commit only on completion; contents survive reset.
    always_ff @(posedge clock) begin
        if (done && hit_ram && !reset) begin
            for (int b = 0; b < 4; b++) begin
                if (wstrb_q[b]) begin
                    ram[ram_idx][8*b +: 8] <= wdata_q[8*b +: 8];
                end
            end
        end
    end

    // FIFO storage write.
    always_ff @(posedge clock) begin
        if (push && !reset) begin
            fifo[wr_ptr] <= wdata_q[7:0];
        end
    end

    // FIFO pointers and occupancy; pointers wrap at the power-of-two depth.
    always_ff @(posedge clock) begin
        if (reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= 5'd0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count <= count + {4'b0, push} - {4'b0, pop};
        end
    end

    assign mem_ready = ready_q;
    assign mem_rdata = rdata_q;
    assign con_valid = count != 5'd0;
    assign con_data  = con_valid ? fifo[rd_ptr] : 8'h00;
    assign bus_error = bus_error_q;

`ifdef RVB_MEM_RESPONDER_LOOKBACK_EN
    logic [39:0] lb_q;
    logic [39:0] lb_next;
    logic        hit_q;

    assign lb_next = {lb_q[31:0], wdata_q[7:0]};

    // Shift pushed console bytes and latch a sticky "ERROR" match.
    always_ff @(posedge clock) begin
        if (reset) begin
            lb_q  <= 40'b0;
            hit_q <= 1'b0;
        end else if (push) begin
            lb_q <= lb_next;
            if (lb_next == 40'h45_52_52_4F_52) begin
                hit_q <= 1'b1;
            end
        end
    end

    assign lookback_hit = hit_q;
`else
    assign lookback_hit = 1'b0;
`endif

endmodule

// File: tb/tb_rvb_mem_responder.sv
// tb_rvb_mem_responder: directed and random checks against a transaction model.
// Lookback expectations follow RVB_MEM_RESPONDER_LOOKBACK_EN.
module tb_rvb_mem_responder;

    localparam int          WC    = 3;
    localparam int          DEPTH = 16;
    localparam logic [31:0] CON   = 32'h1000_0000;
`ifdef RVB_MEM_RESPONDER_LOOKBACK_EN
    localparam logic LB_EXP = 1'b1;
`else
    localparam logic LB_EXP = 1'b0;
`endif

    logic        clock  = 1'b0;
    logic        reset  = 1'b1;
    logic        reset0 = 1'b1;
    logic        mem_valid = 1'b0;
    logic        mem_instr = 1'b0;
    logic [31:0] mem_addr  = 32'b0;
    logic [31:0] mem_wdata = 32'b0;
    logic [3:0]  mem_wstrb = 4'b0;
    logic        con_ready = 1'b0;

    logic        mem_ready, con_valid, bus_error, lookback_hit;
    logic [31:0] mem_rdata;
    logic [7:0]  con_data;
    logic        z_ready, z_con_valid, z_bus_error, z_lookback;
    logic [31:0] z_rdata;
    logic [7:0]  z_con_data;

    always #5 clock = ~clock;

    rvb_mem_responder #(
        .MEM_WORDS(4096), .WAIT_CYCLES(WC),
        .FIFO_DEPTH(DEPTH), .CONSOLE_ADDR(CON)
    ) dut (
        .clock(clock), .reset(reset),
        .mem_valid(mem_valid), .mem_instr(mem_instr),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_wstrb(mem_wstrb), .mem_ready(mem_ready),
        .mem_rdata(mem_rdata), .con_valid(con_valid),
        .con_data(con_data), .con_ready(con_ready),
        .bus_error(bus_error), .lookback_hit(lookback_hit)
    );

    rvb_mem_responder #(
        .MEM_WORDS(4096), .WAIT_CYCLES(0),
        .FIFO_DEPTH(DEPTH), .CONSOLE_ADDR(CON)
    ) dut0 (
        .clock(clock), .reset(reset0),
        .mem_valid(mem_valid), .mem_instr(mem_instr),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_wstrb(mem_wstrb), .mem_ready(z_ready),
        .mem_rdata(z_rdata), .con_valid(z_con_valid),
        .con_data(z_con_data), .con_ready(con_ready),
        .bus_error(z_bus_error), .lookback_hit(z_lookback)
    );

    int   checks = 0;
    int   fails  = 0;
    logic use_z  = 1'b0;
    logic chk_en = 1'b0;
    logic rnd_cr = 1'b0;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, want %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic rdy();
        return use_z ? z_ready : mem_ready;
    endfunction

    function automatic logic [31:0] rdat();
        return use_z ? z_rdata : mem_rdata;
    endfunction

    // ---------------- transaction-level reference model ----------------
    logic [7:0]  q[$];
    logic [7:0]  lb[$];
    logic [31:0] ram_m [int];
    logic [3:0]  known [int];
    int          cyc = 0;
    int          deadline = 0;
    int          phase = 0;
    logic [31:0] t_addr = 32'b0, t_wdata = 32'b0;
    logic [3:0]  t_wstrb = 4'b0;
    logic        exp_ready = 1'b0, exp_berr = 1'b0, exp_lb = 1'b0;
    logic [31:0] exp_rdata = 32'b0, exp_mask = '1;
    string       err_s = "ERROR";

    always @(posedge clock) begin : model
        int       n0;
        int       w;
        logic     push;
        logic     match;
        logic [3:0] k;
        cyc++;
        n0 = q.size();
        push = 1'b0;
        exp_ready = 1'b0;
        exp_rdata = 32'b0;
        exp_mask = '1;
        if (reset) begin
            q.delete();
            lb.delete();
            phase = 0;
            exp_berr = 1'b0;
            exp_lb = 1'b0;
        end else begin
            if (phase == 2) begin
                phase = 0;
            end else if (phase == 0) begin
                if (mem_valid) begin
                    t_addr = mem_addr;
                    t_wdata = mem_wdata;
                    t_wstrb = mem_wstrb;
                    deadline = cyc + WC + 1;
                    phase = 1;
                end
            end else if (cyc >= deadline &&
                         !(t_addr == CON && t_wstrb != 0 && n0 == DEPTH)) begin
                phase = 2;
                exp_ready = 1'b1;
                if (t_addr[31:2] < 30'd4096) begin
                    w = int'(t_addr[31:2]);
                    if (!ram_m.exists(w)) begin
                        ram_m[w] = 32'b0;
                        known[w] = 4'b0;
                    end
                    if (t_wstrb == 4'b0) begin
                        k = known[w];
                        exp_rdata = ram_m[w];
                        exp_mask = {{8{k[3]}}, {8{k[2]}}, {8{k[1]}}, {8{k[0]}}};
                    end else begin
                        for (int b = 0; b < 4; b++) begin
                            if (t_wstrb[b]) begin
                                ram_m[w][8*b +: 8] = t_wdata[8*b +: 8];
                                known[w][b] = 1'b1;
                            end
                        end
                        exp_mask = 32'b0;
                    end
                end else if (t_addr == CON) begin
                    if (t_wstrb == 4'b0) begin
                        exp_rdata = 32'(n0);
                    end else begin
                        push = 1'b1;
                        exp_mask = 32'b0;
                        lb.push_back(t_wdata[7:0]);
                        if (lb.size() > 5) void'(lb.pop_front());
                        match = lb.size() == 5;
                        for (int i = 0; i < 5; i++) begin
                            if (match && lb[i] != err_s[i]) match = 1'b0;
                        end
                        if (match && LB_EXP) exp_lb = 1'b1;
                    end
                end else begin
                    exp_berr = 1'b1;
                end
            end
            if (n0 > 0 && con_ready) void'(q.pop_front());
            if (push) q.push_back(t_wdata[7:0]);
        end
    end

    // Every-cycle comparison of the main DUT against the model.
    always @(negedge clock) begin
        if (chk_en) begin
            check("mem_ready", 32'(mem_ready), 32'(exp_ready));
            check("mem_rdata", mem_rdata & exp_mask, exp_rdata & exp_mask);
            check("con_valid", 32'(con_valid), 32'(q.size() > 0));
            check("con_data", 32'(con_data),
                  q.size() > 0 ? 32'(q[0]) : 32'd0);
            check("bus_error", 32'(bus_error), 32'(exp_berr));
            check("lookback_hit", 32'(lookback_hit), 32'(exp_lb));
        end
    end

    always @(posedge clock) begin
        if (rnd_cr) begin
            #3;
            con_ready = 1'($urandom_range(0, 1));
        end
    end

    // ---------------- driver ----------------
    task automatic start(input logic [31:0] a, input logic [31:0] d,
                         input logic [3:0] s);
        @(posedge clock);
        #2;
        mem_valid = 1'b1;
        mem_instr = 1'($urandom_range(0, 1));
        mem_addr  = a;
        mem_wdata = d;
        mem_wstrb = s;
        @(posedge clock);
        #1;
    endtask

    task automatic finish(input int max, output int lat,
                          output logic [31:0] rd);
        lat = 0;
        while (!rdy() && lat < max) begin
            @(posedge clock);
            #1;
            lat++;
        end
        check("req_done", 32'(rdy()), 32'd1);
        rd = rdat();
        mem_valid = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin : main
        int          lat;
        logic [31:0] rd;
        logic [31:0] a;
        logic [3:0]  s;
        string       msg;

        // Zero-wait-state instance while the main DUT is held in reset.
        use_z = 1'b1;
        repeat (3) @(posedge clock);
        #2 reset0 = 1'b0;
        @(negedge clock);
        check("z_reset_ready", 32'(z_ready), 32'd0);
        check("z_reset_rdata", z_rdata, 32'd0);
        check("z_reset_con_valid", 32'(z_con_valid), 32'd0);
        start(32'h100, 32'hDEAD_BEEF, 4'hF);
        finish(50, lat, rd);
        check("z_wr_latency", 32'(lat), 32'd1);
        start(32'h100, 32'h0, 4'h0);
        finish(50, lat, rd);
        check("z_rd_latency", 32'(lat), 32'd1);
        check("z_rd_data", rd, 32'hDEAD_BEEF);
        @(posedge clock);
        #2 reset0 = 1'b1;

        // Main instance, WAIT_CYCLES=3.
        use_z = 1'b0;
        repeat (2) @(posedge clock);
        #2 reset = 1'b0;
        chk_en = 1'b1;
        @(negedge clock);
        check("rst_mem_ready", 32'(mem_ready), 32'd0);
        check("rst_mem_rdata", mem_rdata, 32'd0);
        check("rst_con_valid", 32'(con_valid), 32'd0);
        check("rst_con_data", 32'(con_data), 32'd0);
        check("rst_bus_error", 32'(bus_error), 32'd0);
        check("rst_lookback", 32'(lookback_hit), 32'd0);

        start(32'h100, 32'hDEAD_BEEF, 4'hF);
        finish(50, lat, rd);
        check("wr_latency", 32'(lat), 32'd4);
        start(32'h100, 32'h0055_0000, 4'b0100);
        finish(50, lat, rd);
        start(32'h100, 32'h0, 4'h0);
        finish(50, lat, rd);
        check("byte_lane_latency", 32'(lat), 32'd4);
        check("byte_lane_data", rd, 32'hDE55_BEEF);

        start(32'h2000_0000, 32'h0, 4'h0);
        finish(50, lat, rd);
        check("unmapped_rdata", rd, 32'd0);
        check("unmapped_bus_error", 32'(bus_error), 32'd1);

        // Fill the console FIFO with no consumer, then overflow by one.
        con_ready = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            start(CON, 32'h40 + 32'(i), 4'h1);
            finish(50, lat, rd);
        end
        start(CON, 32'h0, 4'h0);
        finish(50, lat, rd);
        check("con_count_full", rd, 32'd16);
        start(CON, 32'h50, 4'h1);
        repeat (10) begin
            @(posedge clock);
            #1;
        end
        check("stall_no_ready", 32'(mem_ready), 32'd0);
        @(posedge clock);
        #2 con_ready = 1'b1;
        @(posedge clock);
        #2 con_ready = 1'b0;
        finish(20, lat, rd);
        check("stall_head_popped", 32'(con_data), 32'h41);
        start(CON, 32'h0, 4'h0);
        finish(50, lat, rd);
        check("con_count_refill", rd, 32'd16);
        check("bus_error_sticky", 32'(bus_error), 32'd1);

        con_ready = 1'b1;
        repeat (20) @(posedge clock);
        @(negedge clock);
        check("fifo_drained", 32'(con_valid), 32'd0);

        // Lookback string detect.
        msg = "xERROR";
        for (int i = 0; i < 6; i++) begin
            start(CON, {24'b0, msg[i]}, 4'b0001);
            finish(50, lat, rd);
            if (i == 4) check("lookback_before", 32'(lookback_hit), 32'd0);
        end
        check("lookback_after", 32'(lookback_hit), 32'(LB_EXP));

        // Reset in the middle of a RAM write.
        con_ready = 1'b0;
        start(CON, 32'h61, 4'h1);
        finish(50, lat, rd);
        start(32'h100, 32'h1234_5678, 4'hF);
        @(posedge clock);
        #2;
        reset = 1'b1;
        mem_valid = 1'b0;
        @(posedge clock);
        #2 reset = 1'b0;
        @(negedge clock);
        check("abort_no_ready", 32'(mem_ready), 32'd0);
        check("abort_fifo_empty", 32'(con_valid), 32'd0);
        check("abort_bus_error", 32'(bus_error), 32'd0);
        check("abort_lookback", 32'(lookback_hit), 32'd0);
        start(32'h100, 32'h0, 4'h0);
        finish(50, lat, rd);
        check("abort_ram_kept", rd, 32'hDE55_BEEF);

        // Random traffic with a random consumer.
        rnd_cr = 1'b1;
        for (int n = 0; n < 150; n++) begin
            case ($urandom_range(0, 9))
                0, 1, 2, 3, 4, 5: a = 32'($urandom_range(0, 15)) << 2;
                6, 7, 8:          a = CON;
                default:          a = 32'h8000_0000 | $urandom;
            endcase
            s = ($urandom_range(0, 2) == 0) ? 4'h0 : 4'($urandom);
            start(a, $urandom, s);
            finish(300, lat, rd);
        end
        rnd_cr = 1'b0;
        repeat (3) @(posedge clock);
        chk_en = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures",
                 checks, fails);
        $finish;
    end

endmodule
